noisy_signal_gen: RTL
=====================

NOISY_SIGNAL_GEN -- requirements
Module: noisy_signal_gen

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high (ports clk, rst).
REQ-002 Port clk  input  1  100 MHz sample clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  synchronous active-high reset.
REQ-004 Port en  input  1  advances phase accumulators and LFSR when high.
REQ-005 Port noise_en  input  1  when low, the noise term SHALL be zero.
REQ-006 Port fcw_a  input  24  unsigned frequency control word, tone A (f = fcw*100 MHz/2^24).
REQ-007 Port fcw_b  input  24  unsigned frequency control word, tone B.
REQ-008 Port noisy_signal  output  16  signed sample, FIR filter input stream.
REQ-009 Port sample_valid  output  1  high when noisy_signal reflects an en-qualified sample.

Function
REQ-010 Phase accumulators SHALL be 24-bit: phase <= phase + fcw on each en cycle, with modulo-2^24 wrap and no flag; they hold when en is low.
REQ-011 Stage 1 SHALL register the pre-increment phase[23:16] of each tone and the pre-advance LFSR state in the same cycle as the update.
REQ-012 Phase index mapping SHALL be quadrant = bits[7:6] and address a = bits[5:0].
REQ-013 The quarter-wave LUT SHALL hold 64 signed 16-bit entries: lut[k] = round(32767*sin(pi/2*(k+0.5)/64)), with lut[0]=402 and lut[63]=32765.
REQ-014 Stage 2 SHALL register the quadrant-mapped sine: q0 lut[a], q1 lut[63-a], q2 -lut[a], q3 -lut[63-a].
REQ-015 Stage 2 SHALL register the noise term: LFSR[11:0] as signed 12-bit (range -2048..2047), or 0 if noise_en was low at stage 1.
REQ-016 Stage 3 SHALL register noisy_signal = (sinA >>> 1) + (sinB >>> 2) + noise, using 18-bit signed intermediate arithmetic shifts (floor rounding).
REQ-017 The magnitude bound is 16383+8192+2048 < 32768, so the result SHALL be taken as the low 16 bits with no saturation logic.
REQ-018 The LFSR SHALL be a 16-bit Galois LFSR, right-shifting, with XOR mask 16'hB400 applied when the shifted-out bit is 1; it advances only on en cycles.
REQ-019 Latency SHALL be exactly 3 cycles from an en-high edge to the corresponding noisy_signal; sample_valid is en delayed by 3 registers.
REQ-020 With en low, the pipeline keeps flowing and stage 1 re-samples the held phase and LFSR, so the output repeats the held sample with sample_valid=0.
REQ-021 fcw changes SHALL take effect on the next en cycle; no glitch or phase reset is permitted.
REQ-022 Throughput SHALL be one sample per clock while en is continuously high.

Reset
REQ-023 On rst high at a clock edge, both phases SHALL be set to 0, the LFSR to 16'hACE1, all pipeline registers to 0, noisy_signal to 0 and sample_valid to 0.
REQ-024 rst SHALL take priority over en; reset mid-stream SHALL flush the 3 in-flight samples, and sample_valid stays low for 3 cycles after rst deasserts, even with en high.
REQ-025 The first sample after reset (en=1) SHALL use phase 0 and LFSR 16'hACE1.

Structure
REQ-026 Package noisy_signal_pkg SHALL hold PHASE_W=24, LUT_AW=6, LFSR_SEED=16'hACE1, LFSR_MASK=16'hB400 and the 64-entry LUT constant.
REQ-027 One sub-module, sine_quarter_lut, SHALL be instantiated twice (tones A and B); it takes quadrant/address, registers its output (stage 2), and holds no other state.
REQ-028 The design SHALL contain no latches, no multipliers and no asynchronous logic.

Verification
REQ-029 Scenario: reset, en=1, fcw_a=fcw_b=0, noise_en=1 -> first valid sample = 201+100-799 = -498, 3 cycles after en.
REQ-030 Scenario: fcw_a=24'h400000, fcw_b=0, noise_en=0, en=1 -> repeating sequence 301, 16482, -101, -16283.
REQ-031 Scenario: en toggling 1,0,1 -> sample_valid pattern is the same toggle delayed 3 cycles, and the held sample repeats while invalid.
REQ-032 Scenario: noise_en=0, fcw both 0 over 1000 cycles -> constant 301; noise_en=1 -> LFSR period 65535 with no all-zero state.
REQ-033 Scenario: rst asserted mid-stream -> next cycle outputs are 0/0, and the post-reset sequence is identical to the first run.
REQ-034 Scenario: fcw_a=24'hFFFFFF with noise at extremes -> no wrap of noisy_signal; compare against a bit-exact reference model.

Source files
------------

// File: rtl/noisy_signal_pkg.sv
// Shared constants for the two-tone plus noise sample generator: phase width,
// quarter-wave sine table, LFSR seed/mask and the LFSR step function.
package noisy_signal_pkg;

  localparam int PHASE_W   = 24;
  localparam int LUT_AW    = 6;
  localparam int LUT_DEPTH = 1 << LUT_AW;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Half-LSB offset sampling: round(32767*sin(pi/2*(k+0.5)/64)), so no entry is 0 or full scale.
  localparam logic signed [15:0] SINE_LUT [LUT_DEPTH] = '{
    16'sd402,   16'sd1206,  16'sd2009,  16'sd2811,  16'sd3612,  16'sd4410,  16'sd5205,  16'sd5998,
    16'sd6786,  16'sd7571,  16'sd8351,  16'sd9126,  16'sd9896,  16'sd10659, 16'sd11417, 16'sd12167,
    16'sd12910, 16'sd13645, 16'sd14372, 16'sd15090, 16'sd15800, 16'sd16499, 16'sd17189, 16'sd17869,
    16'sd18537, 16'sd19195, 16'sd19841, 16'sd20475, 16'sd21096, 16'sd21705, 16'sd22301, 16'sd22884,
    16'sd23452, 16'sd24007, 16'sd24547, 16'sd25072, 16'sd25582, 16'sd26077, 16'sd26556, 16'sd27019,
    16'sd27466, 16'sd27896, 16'sd28310, 16'sd28706, 16'sd29085, 16'sd29447, 16'sd29791, 16'sd30117,
    16'sd30424, 16'sd30714, 16'sd30985, 16'sd31237, 16'sd31470, 16'sd31685, 16'sd31880, 16'sd32057,
    16'sd32213, 16'sd32351, 16'sd32469, 16'sd32567, 16'sd32646, 16'sd32705, 16'sd32745, 16'sd32765
  };

  // Right-shifting Galois step; the mask folds in only when a 1 is shifted out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// Quadrant-mapped quarter-wave sine lookup; one registered stage, no other state.
// Always accepts a new index each cycle; no backpressure.
module sine_quarter_lut
  import noisy_signal_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        quad,
  input  logic [LUT_AW-1:0] addr,
  output logic [15:0]       sine
);

  logic [LUT_AW-1:0] lut_addr;
  logic [15:0]       mag;

  // Odd quadrants walk the table backwards (63-a == ~a); upper half negates.
  always_comb begin
    lut_addr = quad[0] ? ~addr : addr;
    mag      = SINE_LUT[lut_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sine <= '0;
    end else begin
      sine <= quad[1] ? (16'd0 - mag) : mag;
    end
  end

endmodule

// File: rtl/noisy_signal_gen.sv
// Two DDS tones plus optional 12-bit LFSR noise as a 16-bit signed stream; 3-cycle latency.
// No backpressure: en advances phase/LFSR, the pipeline flows every cycle and sample_valid tags en samples.
module noisy_signal_gen
  import noisy_signal_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               noise_en,
  input  logic [PHASE_W-1:0] fcw_a,
  input  logic [PHASE_W-1:0] fcw_b,
  output logic [15:0]        noisy_signal,
  output logic               sample_valid
);

  logic [PHASE_W-1:0] phase_a;
  logic [PHASE_W-1:0] phase_b;
  logic [15:0]        lfsr;

  logic [7:0]  s1_idx_a;
  logic [7:0]  s1_idx_b;
  logic [11:0] s1_noise;
  logic        s1_noise_en;
  logic        s1_vld;

  logic [15:0] sin_a;
  logic [15:0] sin_b;
  logic [11:0] s2_noise;
  logic        s2_vld;

  logic signed [17:0] term_a;
  logic signed [17:0] term_b;
  logic signed [17:0] term_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_a <= '0;
      phase_b <= '0;
      lfsr    <= LFSR_SEED;
    end else if (en) begin
      phase_a <= phase_a + fcw_a;
      phase_b <= phase_b + fcw_b;
      lfsr    <= lfsr_next(lfsr);
    end
  end

  // Stage 1 samples every cycle, so with en low it keeps re-reading the held state.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_idx_a    <= '0;
      s1_idx_b    <= '0;
      s1_noise    <= '0;
      s1_noise_en <= 1'b0;
      s1_vld      <= 1'b0;
    end else begin
      s1_idx_a    <= phase_a[PHASE_W-1 -: 8];
      s1_idx_b    <= phase_b[PHASE_W-1 -: 8];
      s1_noise    <= lfsr[11:0];
      s1_noise_en <= noise_en;
      s1_vld      <= en;
    end
  end

  sine_quarter_lut u_lut_a (
    .clk  (clk),
    .rst  (rst),
    .quad (s1_idx_a[7:6]),
    .addr (s1_idx_a[5:0]),
    .sine (sin_a)
  );

  sine_quarter_lut u_lut_b (
    .clk  (clk),
    .rst  (rst),
    .quad (s1_idx_b[7:6]),
    .addr (s1_idx_b[5:0]),
    .sine (sin_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_noise <= '0;
      s2_vld   <= 1'b0;
    end else begin
      s2_noise <= s1_noise_en ? s1_noise : 12'd0;
      s2_vld   <= s1_vld;
    end
  end

  // Worst case 16383+8192+2048 stays inside 16 bits, so truncation never wraps.
  always_comb begin
    term_a = $signed({{2{sin_a[15]}}, sin_a}) >>> 1;
    term_b = $signed({{2{sin_b[15]}}, sin_b}) >>> 2;
    term_n = $signed({{6{s2_noise[11]}}, s2_noise});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      noisy_signal <= '0;
      sample_valid <= 1'b0;
    end else begin
      noisy_signal <= 16'(term_a + term_b + term_n);
      sample_valid <= s2_vld;
    end
  end

endmodule
